// File: rtl/lsu_data_mem.sv
// lsu_data_mem: single-port load/store data memory with a valid/ready request and response and one access per cycle.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being forced aligned.
module lsu_data_mem #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP_MISALIGN = 1'b1;
`else
  localparam logic TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_init_done;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_consume;
  logic             w_oor;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_fault;
  logic             w_wr_en;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_place;
  logic [31:0]      w_wr_word;
  logic [31:0]      w_load_data;
  logic [3:0]       w_be;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    case (lane)
      2'b00:   h = word[15:0];
      2'b01:   h = word[23:8];
      default: h = word[31:16];
    endcase
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      2'b10:   res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign req_ready = r_init_done & ((r_state == ST_IDLE) | rsp_ready);
  assign w_accept  = req_valid & req_ready;
  assign w_consume = rsp_valid & rsp_ready;

  assign w_idx     = req_addr[IDX_W+1:2];
  assign w_oor     = (req_addr >> (IDX_W + 2)) != {ADDR_W{1'b0}};
  assign w_illegal = (req_size == 2'b11);
  assign w_fault   = w_oor | w_illegal | (w_misalign & TRAP_MISALIGN);
  assign w_wr_en   = w_accept & req_we & ~w_fault;

  // Lane selection: misaligned accesses are snapped down to their natural alignment.
  always_comb begin
    w_misalign = 1'b0;
    w_lane     = req_addr[1:0];
    case (req_size)
      2'b01: begin
        if (req_addr[1:0] == 2'b11) begin
          w_misalign = 1'b1;
          w_lane     = 2'b10;
        end else begin
          w_lane     = req_addr[1:0];
        end
      end
      2'b10: begin
        w_misalign = (req_addr[1:0] != 2'b00);
        w_lane     = 2'b00;
      end
      default: begin
        w_lane     = req_addr[1:0];
      end
    endcase
  end

  assign w_rd_word   = r_mem[w_idx];
  assign w_be        = byte_en(req_size, w_lane);
  assign w_place     = req_wdata << {w_lane, 3'b000};
  assign w_wr_word   = merge_bytes(w_rd_word, w_place, w_be);
  assign w_load_data = load_extract(w_rd_word, req_size, w_lane, req_unsigned);

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // Holds off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          w_state_nxt = ST_RESP;
        end else if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response payload: captured at acceptance, held through a stall, cleared once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (req_we | w_fault) ? 32'd0 : w_load_data;
      r_err   <= w_fault;
    end else if (w_consume) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: directed scenarios plus random traffic against a byte-array model.
module tb_lsu_data_mem;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [0:DEPTH*4-1];

  lsu_data_mem #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Byte-level reference: an access that would cross a word boundary is misaligned.
  function automatic void model_access(input bit we, input logic [1:0] size, input bit uns,
      input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int a;
    int nb;
    rd = 32'd0;
    err = 1'b0;
    if (size == 2'd3 || addr >= 32'(DEPTH*4)) begin
      err = 1'b1;
      return;
    end
    a = int'(addr);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if ((a % 4) + nb > 4) begin
      if (TRAP) begin
        err = 1'b1;
        return;
      end
      a = a - (a % nb);
    end
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[a+i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd = rd | (32'(mdl[a+i]) << (8*i));
      if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFFFFFF << (8*nb));
    end
  endfunction

  task automatic xact(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output bit err, output bit ok);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = (req_ready === 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = ok && (rsp_valid === 1'b1);
    rd = rsp_rdata;
    err = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b rdata=%h err=%b, expected 0 0 00000000 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_no_accept: got rsp_valid=%b, expected 0", rsp_valid);
    end
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd;
    logic [31:0] erd;
    bit err;
    bit eerr;
    bit ok;
    for (int w = 0; w < DEPTH; w++) begin
      xact(1'b1, 2'b10, 1'b0, 32'(w*4), $urandom, rd, err, ok);
      model_access(1'b1, 2'b10, 1'b0, 32'(w*4), req_wdata, erd, eerr);
      checks++;
      if (!ok || err !== eerr || rd !== erd) begin
        errors++;
        $display("FAIL init_store %0d: got ok=%b err=%b rdata=%h, expected ok=1 err=%b rdata=%h",
                 w, ok, err, rd, eerr, erd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bit err;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF; rsp_ready = 1'b1;
    @(posedge clk); #1;
    model_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_store: got valid=%b err=%b ready=%b, expected 1 0 1", rsp_valid, rsp_err, req_ready);
    end
    req_we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: got valid=%b rdata=%h err=%b, expected 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got rsp_valid=%b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_byte_ext();
    logic [31:0] rd;
    logic [31:0] erd;
    bit err;
    bit eerr;
    bit ok;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, ok);
    model_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, erd, eerr);
    xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h80, rd, err, ok);
    model_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h80, erd, eerr);
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, err, ok);
    checks++;
    if (!ok || rd !== 32'hFFFFFF80 || err !== 1'b0) begin
      errors++;
      $display("FAIL lb_signed: got rdata=%h err=%b, expected ffffff80 0", rd, err);
    end
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, err, ok);
    checks++;
    if (!ok || rd !== 32'h00000080 || err !== 1'b0) begin
      errors++;
      $display("FAIL lb_unsigned: got rdata=%h err=%b, expected 00000080 0", rd, err);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, ok);
    checks++;
    if (!ok || rd !== 32'h00008000 || err !== 1'b0) begin
      errors++;
      $display("FAIL lw_after_sb: got rdata=%h err=%b, expected 00008000 0", rd, err);
    end
  endtask

  task automatic test_stall();
    logic [31:0] erd;
    logic [31:0] held;
    bit eerr;
    model_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, erd, eerr);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    held = rsp_rdata;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd || held !== erd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: got valid=%b rdata=%h ready=%b, expected 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, erd);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got rsp_valid=%b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd;
    logic [31:0] erd;
    bit err;
    bit eerr;
    bit ok;
    model_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, erd, eerr);
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, rd, err, ok);
    checks++;
    if (!ok || err !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL oor_store: got err=%b rdata=%h, expected 1 00000000", err, rd);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, err, ok);
    checks++;
    if (!ok || err !== 1'b0 || rd !== erd) begin
      errors++;
      $display("FAIL oor_no_alias: got err=%b rdata=%h, expected 0 %h", err, rd, erd);
    end
    xact(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, rd, err, ok);
    checks++;
    if (!ok || err !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL illegal_size: got err=%b rdata=%h, expected 1 00000000", err, rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic [31:0] erd;
    bit err;
    bit eerr;
    bit ok;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017F55, rd, err, ok);
    model_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017F55, erd, eerr);
    xact(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, err, ok);
    checks++;
    if (TRAP) begin
      if (!ok || err !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL lh_misaligned: got err=%b rdata=%h, expected 1 00000000", err, rd);
      end
    end else begin
      if (!ok || err !== 1'b0 || rd !== 32'hFFFF8001) begin
        errors++;
        $display("FAIL lh_misaligned: got err=%b rdata=%h, expected 0 ffff8001", err, rd);
      end
    end
    xact(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, rd, err, ok);
    checks++;
    if (!ok || err !== 1'b0 || rd !== 32'h0000017F) begin
      errors++;
      $display("FAIL lh_lane1: got err=%b rdata=%h, expected 0 0000017f", err, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] erd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    bit we;
    bit uns;
    bit err;
    bit eerr;
    bit ok;
    int sel;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      wd = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) addr = $urandom | 32'h80000000;
      else if (sel < 3) addr = 32'($urandom_range(256, 511));
      else addr = 32'($urandom_range(0, DEPTH*4-1));
      xact(we, size, uns, addr, wd, rd, err, ok);
      model_access(we, size, uns, addr, wd, erd, eerr);
      checks++;
      if (!ok || rd !== erd || err !== eerr) begin
        errors++;
        $display("FAIL random %0d we=%b size=%0d uns=%b addr=%h: got ok=%b rdata=%h err=%b, expected rdata=%h err=%b",
                 i, we, size, uns, addr, ok, rd, err, erd, eerr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] erd;
    bit err;
    bit eerr;
    bit ok;
    model_access(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, erd, eerr);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h24; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pending: got rsp_valid=%b, expected 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got valid=%b ready=%b rdata=%h, expected 0 0 00000000",
               rsp_valid, req_ready, rsp_rdata);
    end
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, rd, err, ok);
    checks++;
    if (!ok || rd !== erd || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_retain: got ok=%b rdata=%h err=%b, expected rdata=%h err=0", ok, rd, err, erd);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_back_to_back();
    test_byte_ext();
    test_stall();
    test_range();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words; power of two, at least 4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 rsp_err  output  1  access faulted; no state changed.

Function
REQ-016 Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1; a response is consumed on a rising edge where rsp_valid=1 and rsp_ready=1.
REQ-017 FSM states:
- IDLE: rsp_valid=0, req_ready=1.
- RESP: rsp_valid=1, req_ready=rsp_ready.
REQ-018 Transitions:
- IDLE to RESP on acceptance.
- RESP to IDLE when the response is consumed and no new request is accepted.
- RESP stays in RESP when the response is consumed and a new request is accepted in the same cycle; this gives one access per cycle.
REQ-019 Latency: a response is valid in the cycle after acceptance, for both loads and stores.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err hold stable.
REQ-021 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; lane = req_addr[1:0].
REQ-022 Out-of-range: any address bit at or above log2(DEPTH_WORDS)+2 set produces rsp_err=1, with no write and rdata 0.
REQ-023 req_size=11 produces rsp_err=1, with no write and rdata 0.
REQ-024 Store byte enables:
- byte: one lane selected by lane.
- half: lanes {lane+1, lane}.
- word: all four lanes.
- Write data bits [7:0] or [15:0] are placed on the selected lanes; unselected bytes are unchanged.
REQ-025 The store commits on the acceptance edge; a load accepted the next cycle returns the new data.
REQ-026 Load: read the word at acceptance, extract the selected lane(s), then sign- or zero-extend per req_unsigned; word loads are passed through unchanged.
REQ-027 Half accesses with lane=11 and word accesses with lane not 00 are misaligned; behaviour is defined under Configuration.

Reset
REQ-028 While rst_n=0:
- state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready=0 during reset; it rises to 1 in IDLE after release.
REQ-029 Reset mid-operation discards any pending response; memory contents are not reset and not written during reset.
REQ-030 A request presented during the cycle of rst_n release is not accepted.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN:
- Defined: misaligned accesses return rsp_err=1 with no write and rdata 0.
- Undefined: misaligned accesses are forced aligned by clearing addr[0] for half and addr[1:0] for word; rsp_err=0.

Verification
REQ-032 Store word 0xDEADBEEF to 0x10, then back-to-back load word 0x10 -> rsp_rdata=0xDEADBEEF one cycle after load acceptance, rsp_err=0.
REQ-033 Store byte 0x80 to 0x11 over 0x00000000, then load byte signed 0x11 -> 0xFFFFFF80; load byte unsigned 0x11 -> 0x00000080; load word 0x10 -> 0x00008000.
REQ-034 Load with rsp_ready held 0 for 3 cycles:
- rsp_valid=1 and rsp_rdata stable all 3 cycles.
- req_ready=0 during the stall.
- Response consumed on the cycle rsp_ready=1.
REQ-035 With DEPTH_WORDS=64, store to 0x100 -> rsp_err=1; a subsequent load of 0x000 is unchanged.
REQ-036 Load half at 0x13:
- With macro defined -> rsp_err=1, rdata 0.
- Without macro -> data from 0x12, rsp_err=0.
REQ-037 Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately; after release the earlier-stored data is still readable.
